// File: rtl/aec_pkg.sv
`default_nettype none
// ============================================================================
// Module   : aec_pkg
// Purpose  : Shared definitions for the AEC ASCII character protocol:
//            character constants, transmitter state encoding and the
//            nibble-to-ASCII digit map.
// Revision : 1.0  initial release
// ============================================================================
package aec_pkg;

    localparam logic [7:0] c_zero    = 8'h30;
    localparam logic [7:0] c_lower_a = 8'h61;
    localparam logic [7:0] c_eq      = 8'h3D;
    localparam logic [7:0] c_nul     = 8'h00;

    // Each state names what ascii_out is carrying during that cycle.
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HI   = 3'd1,
        S_LO   = 3'd2,
        S_EQ   = 3'd3,
        S_GAP  = 3'd4
    } tx_state_t;

    // Lowercase hex digit for a 4-bit value.
    function automatic logic [7:0] nibble_to_ascii(input logic [3:0] d);
        if (d < 4'd10) begin
            return c_zero + {4'h0, d};
        end
        return c_lower_a + {4'h0, d} - 8'd10;
    endfunction

endpackage
`default_nettype wire

// File: rtl/aec_ascii_tx_if.sv
`default_nettype none
// ============================================================================
// Module   : aec_ascii_tx_if
// Purpose  : Producer-side result push and character-stream outputs of the
//            AEC ASCII transmitter.
// Revision : 1.0  initial release
// ============================================================================
interface aec_ascii_tx_if;

    logic       valid_in;
    logic [6:0] result_in;
    logic       ready;
    logic [7:0] ascii_out;
    logic       busy;
    logic       full;
    logic       overflow;

    // Producer / observer side
    modport master (
        output valid_in,
        output result_in,
        input  ready,
        input  ascii_out,
        input  busy,
        input  full,
        input  overflow
    );

    // Transmitter side
    modport slave (
        input  valid_in,
        input  result_in,
        output ready,
        output ascii_out,
        output busy,
        output full,
        output overflow
    );

endinterface
`default_nettype wire

// File: rtl/aec_result_fifo.sv
`default_nettype none
// ============================================================================
// Module   : aec_result_fifo
// Purpose  : Synchronous DEPTH x 7 result FIFO. Simultaneous push and pop are
//            both honoured even when full; a push into a full FIFO without a
//            pop is dropped and flagged on o_drop in the same cycle.
// Revision : 1.0  initial release
// ============================================================================
module aec_result_fifo #(
    parameter int DEPTH = 4
) (
    input  wire logic       clk,
    input  wire logic       rst,
    input  wire logic       i_push,
    input  wire logic [6:0] i_push_data,
    input  wire logic       i_pop,
    output logic      [6:0] o_pop_data,
    output logic            o_empty,
    output logic            o_full,
    output logic            o_drop
);

    localparam int c_aw = $clog2(DEPTH);
    localparam int c_cw = $clog2(DEPTH) + 1;
    localparam logic [c_cw-1:0] c_depth_cnt = c_cw'(DEPTH);

    logic [6:0]      r_mem [DEPTH];
    logic [c_aw-1:0] r_wr_ptr;
    logic [c_aw-1:0] r_rd_ptr;
    logic [c_cw-1:0] r_count;
    logic            r_empty;
    logic            r_full;

    logic            w_do_pop;
    logic            w_do_push;
    logic [c_cw-1:0] w_count_nxt;

    // A pop frees a slot in the same cycle, so a push into a full FIFO
    // still lands when it coincides with a pop.
    assign w_do_pop  = i_pop && !r_empty;
    assign w_do_push = i_push && (!r_full || w_do_pop);

    assign o_pop_data = r_mem[r_rd_ptr];
    assign o_empty    = r_empty;
    assign o_full     = r_full;
    assign o_drop     = i_push && r_full && !w_do_pop;

    // Next occupancy, shared by the count and the registered flags.
    always_comb begin
        w_count_nxt = r_count;
        if (w_do_push && !w_do_pop) begin
            w_count_nxt = r_count + 1'b1;
        end else if (!w_do_push && w_do_pop) begin
            w_count_nxt = r_count - 1'b1;
        end
    end

    // Storage array; no reset needed since pointers gate every read.
    always_ff @(posedge clk) begin
        if (rst && w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // Pointers (wrap naturally for power-of-two depth), count and flags.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_empty  <= 1'b1;
            r_full   <= 1'b0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= w_count_nxt;
            r_empty <= (w_count_nxt == '0);
            r_full  <= (w_count_nxt == c_depth_cnt);
        end
    end

endmodule
`default_nettype wire

// File: rtl/aec_ascii_tx.sv
`default_nettype none
// ============================================================================
// Module   : aec_ascii_tx
// Purpose  : AEC ASCII transmitter. Buffers 7-bit results and sends each as
//            lowercase hex digits (leading zero suppressed) followed by '=',
//            then IDLE_GAP zero cycles and one idle cycle.
// Revision : 1.0  initial release
// ============================================================================
module aec_ascii_tx
    import aec_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int IDLE_GAP = 2
) (
    input  wire logic     clk,
    input  wire logic     rst,
    aec_ascii_tx_if.slave bus
);

    localparam int c_gap_w = (IDLE_GAP > 1) ? $clog2(IDLE_GAP) : 1;
    localparam logic [c_gap_w-1:0] c_gap_last = c_gap_w'((IDLE_GAP > 0) ? IDLE_GAP - 1 : 0);

    tx_state_t          r_state;
    logic [7:0]         r_ascii;
    logic               r_ready;
    logic               r_busy;
    logic               r_overflow;
    logic [3:0]         r_lo;
    logic [c_gap_w-1:0] r_gap_cnt;

    logic               w_pop;
    logic [6:0]         w_pop_data;
    logic               w_empty;
    logic               w_full;
    logic               w_drop;

    // The FSM only takes a new result while idle; the FIFO ignores the pop
    // when empty.
    assign w_pop = (r_state == S_IDLE);

    aec_result_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (bus.valid_in),
        .i_push_data (bus.result_in),
        .i_pop       (w_pop),
        .o_pop_data  (w_pop_data),
        .o_empty     (w_empty),
        .o_full      (w_full),
        .o_drop      (w_drop)
    );

    assign bus.ready     = r_ready;
    assign bus.ascii_out = r_ascii;
    assign bus.busy      = r_busy;
    assign bus.full      = w_full;
    assign bus.overflow  = r_overflow;

    // Sticky record of any dropped push; only reset clears it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end
    end

    // Frame sequencer: registers the character for the next cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_ascii   <= c_nul;
            r_ready   <= 1'b0;
            r_busy    <= 1'b0;
            r_lo      <= 4'h0;
            r_gap_cnt <= '0;
        end else begin
            r_ready <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (!w_empty) begin
                        r_lo    <= w_pop_data[3:0];
                        r_busy  <= 1'b1;
                        r_ready <= 1'b1;
                        if (w_pop_data[6:4] != 3'd0) begin
                            r_ascii <= nibble_to_ascii({1'b0, w_pop_data[6:4]});
                            r_state <= S_HI;
                        end else begin
                            r_ascii <= nibble_to_ascii(w_pop_data[3:0]);
                            r_state <= S_LO;
                        end
                    end
                end
                S_HI: begin
                    r_ascii <= nibble_to_ascii(r_lo);
                    r_state <= S_LO;
                end
                S_LO: begin
                    r_ascii <= c_eq;
                    r_state <= S_EQ;
                end
                S_EQ: begin
                    r_ascii   <= c_nul;
                    r_gap_cnt <= '0;
                    if (IDLE_GAP == 0) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_state <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (r_gap_cnt == c_gap_last) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 1'b1;
                    end
                end
                default: begin
                    r_ascii <= c_nul;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
